// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter_if : single-port request/grant/response memory bus, rev 1.0   |
// +--------------------------------------------------------------------------+
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_bit_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_bit_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_bit_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter : fetch/load-store arbiter onto one memory port, rev 1.0      |
// | MEM_ARB_RR_EN selects round-robin instead of fixed D-over-I priority.     |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_bit_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              core_stall,
  mem_arbiter_if.master     mem
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_bit_we_q, mem_bit_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_valid_q, i_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              i_elig, d_elig, d_wins;
`ifdef MEM_ARB_RR_EN
  logic              last_owner_q, last_owner_d;
`endif

  assign core_stall = (i_req & ~i_done_q) | (d_req & ~d_done_q);

  always_comb begin
    i_elig = i_req & ~i_done_q;
    d_elig = d_req & ~d_done_q;
`ifdef MEM_ARB_RR_EN
    // On contention the port that was not served last takes the bus.
    d_wins = d_elig & (~i_elig | (last_owner_q == OWN_I));
`else
    d_wins = d_elig;
`endif
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    i_done_d     = i_done_q;
    d_done_d     = d_done_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_bit_we_d = mem_bit_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_valid_d    = 1'b0;
    d_valid_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    // Done flags live only until the pipeline is released.
    if (!core_stall) begin
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_elig | d_elig) begin
          owner_d   = d_wins ? OWN_D : OWN_I;
          mem_req_d = 1'b1;
          state_d   = ST_REQ;
          if (d_wins) begin
            mem_we_d     = d_we;
            mem_bit_we_d = d_bit_we;
            mem_addr_d   = d_addr;
            mem_wdata_d  = d_wdata;
          end else begin
            mem_we_d     = 1'b0;
            mem_bit_we_d = '0;
            mem_addr_d   = i_addr;
            mem_wdata_d  = '0;
          end
        end
      end
      ST_REQ: begin
        if (mem.mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem.mem_rvalid) begin
          if (owner_q == OWN_D) begin
            d_rdata_d = mem.mem_rdata;
            d_valid_d = 1'b1;
          end else begin
            i_rdata_d = mem.mem_rdata;
            i_valid_d = 1'b1;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (owner_q == OWN_D) begin
          d_done_d = 1'b1;
        end else begin
          i_done_d = 1'b1;
        end
`ifdef MEM_ARB_RR_EN
        last_owner_d = owner_q;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_bit_we_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_valid_q    <= 1'b0;
      d_valid_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWN_I;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_bit_we_q <= mem_bit_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_valid_q    <= i_valid_d;
      d_valid_q    <= d_valid_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign mem.mem_req    = mem_req_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_bit_we = mem_bit_we_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_wdata  = mem_wdata_q;
  assign i_rdata        = i_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign i_valid        = i_valid_q;
  assign d_valid        = d_valid_q;

endmodule
`default_nettype wire
